mem_dump_reader: RTL and testbench

- Read-only consumer of the processor's data RAM.
- On a rising edge of the core's dump request, walks a word-aligned address window, reads each 32-bit word and serializes it LSB-byte-first over an 8N1 UART TX line.
- Sits beside the processor and data RAM and takes the RAM port while the core is held off.
- Used to extract memory contents to a host after a program run.

---
 rtl/mem_dump_reader_if.sv | 28 ++
 rtl/mem_dump_reader.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_dump_reader.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dump_reader_if.sv
// mem_dump_reader_if
//   Read port between the memory dump reader and the processor's data RAM.
//   Signals:
//     mem_rd_en  read strobe toward the RAM
//     mem_addr   word-aligned byte address toward the RAM (ADDR_W bits)
//     mem_data   32-bit read data, valid the cycle after mem_rd_en
//   Modports:
//     master  the dump reader (drives strobe/address, receives data)
//     slave   the RAM read port
interface mem_dump_reader_if #(
   parameter int ADDR_W = 7
);
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_data;

   modport master (
      output mem_rd_en,
      output mem_addr,
      input  mem_data
   );

   modport slave (
      input  mem_rd_en,
      input  mem_addr,
      output mem_data
   );
endinterface

// File: rtl/mem_dump_reader.sv
// mem_dump_reader
//   Read-only consumer of the processor's data RAM. On a 0->1 edge of
//   dump_req it walks the byte-address window [START_ADDR, END_ADDR] in
//   steps of 4, reads each 32-bit word and sends it LSB-byte-first as 8N1
//   frames on tx (start bit 0, 8 data bits LSB first, stop bit 1).
//
//   Ports:
//     CLK       system clock, rising edge
//     RST       asynchronous active-low reset
//     dump_req  level request; a dump starts on its registered 0->1 edge
//     mem       RAM read port (mem_dump_reader_if.master)
//     busy      high from accepted request through the done cycle
//     done      one-cycle pulse after the last stop bit
//     tx        UART serial output, idle high
//
//   Optional feature: define DUMP_HEADER_EN to send a two-byte header
//   (0xA5, START_ADDR[7:0]) before the first RAM read. With the macro
//   undefined no header logic exists.
module mem_dump_reader #(
   parameter int ADDR_W       = 7,
   parameter int START_ADDR   = 0,
   parameter int END_ADDR     = 124,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              dump_req,
   mem_dump_reader_if.master mem,
   output logic              busy,
   output logic              done,
   output logic              tx
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(END_ADDR);
`ifdef DUMP_HEADER_EN
   localparam logic [7:0] HDR_SYNC = 8'hA5;
   localparam logic [7:0] HDR_ADDR = 8'(START_ADDR);
`endif

   typedef enum logic [2:0] {
      S_IDLE,
`ifdef DUMP_HEADER_EN
      S_HDR,
`endif
      S_READ,
      S_CAPTURE,
      S_SEND,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       word_q, word_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [3:0]        bit_idx_q, bit_idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rd_en_q, rd_en_d;

   logic              start;
   logic              in_frame;
   logic              bit_end;
   logic              frame_end;
   logic              next_in_frame;
   logic [7:0]        next_byte;
   logic [31:0]       word_sh;

   // Bit 0 is the start bit, 1..8 are data LSB first, 9 is the stop bit.
   function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
      logic [7:0] sh;
      sh = data >> (idx - 4'd1);
      if (idx == 4'd0) begin
         return 1'b0;
      end else if (idx >= 4'd9) begin
         return 1'b1;
      end else begin
         return sh[0];
      end
   endfunction

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= S_IDLE;
         req_q      <= 1'b0;
         addr_q     <= FIRST_ADDR;
         word_q     <= '0;
         byte_idx_q <= '0;
         bit_idx_q  <= '0;
         cnt_q      <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_en_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         word_q     <= word_d;
         byte_idx_q <= byte_idx_d;
         bit_idx_q  <= bit_idx_d;
         cnt_q      <= cnt_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_en_q    <= rd_en_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      req_d      = dump_req;
      addr_d     = addr_q;
      word_d     = word_q;
      byte_idx_d = byte_idx_q;
      bit_idx_d  = bit_idx_q;
      cnt_d      = cnt_q;

      // Only evaluated in IDLE, so edges seen while busy are dropped.
      start = dump_req && !req_q;

      in_frame = (state_q == S_SEND)
`ifdef DUMP_HEADER_EN
                 || (state_q == S_HDR)
`endif
                 ;
      bit_end   = (cnt_q == CNT_LAST);
      frame_end = in_frame && bit_end && (bit_idx_q == 4'd9);

      // Shared bit/byte timing for header and data frames.
      if (in_frame) begin
         if (bit_end) begin
            cnt_d = '0;
            if (bit_idx_q == 4'd9) begin
               bit_idx_d = '0;
            end else begin
               bit_idx_d = bit_idx_q + 4'd1;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (frame_end) begin
            byte_idx_d = byte_idx_q + 2'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d     = FIRST_ADDR;
               byte_idx_d = '0;
               bit_idx_d  = '0;
               cnt_d      = '0;
`ifdef DUMP_HEADER_EN
               state_d    = S_HDR;
`else
               state_d    = S_READ;
`endif
            end
         end
`ifdef DUMP_HEADER_EN
         S_HDR: begin
            if (frame_end && (byte_idx_q == 2'd1)) begin
               state_d = S_READ;
            end
         end
`endif
         S_READ: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            word_d     = mem.mem_data;
            byte_idx_d = '0;
            bit_idx_d  = '0;
            cnt_d      = '0;
            state_d    = S_SEND;
         end
         S_SEND: begin
            if (frame_end && (byte_idx_q == 2'd3)) begin
               // Equality stop means the address never needs to wrap.
               if (addr_q == LAST_ADDR) begin
                  state_d = S_DONE;
               end else begin
                  addr_d  = addr_q + ADDR_W'(4);
                  state_d = S_READ;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered from next-state values so they line up
      // with state_q cycle for cycle without combinational glitches.
      word_sh   = word_d >> {byte_idx_d, 3'b000};
      next_byte = word_sh[7:0];
      next_in_frame = (state_d == S_SEND);
`ifdef DUMP_HEADER_EN
      if (state_d == S_HDR) begin
         next_in_frame = 1'b1;
         next_byte     = (byte_idx_d == 2'd0) ? HDR_SYNC : HDR_ADDR;
      end
`endif
      tx_d    = next_in_frame ? frame_bit(next_byte, bit_idx_d) : 1'b1;
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
      rd_en_d = (state_d == S_READ);
   end

   assign mem.mem_rd_en = rd_en_q;
   assign mem.mem_addr  = addr_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign tx            = tx_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader
//   Two readers share one RAM model: channel 0 dumps bytes 0..8, channel 1
//   dumps the single word at 4. Expected tx bytes and read addresses are
//   queued when a dump is requested; a negedge monitor decodes UART frames
//   and read strobes and pops/compares against those queues.
module tb_mem_dump_reader;
   localparam int C  = 4;
   localparam int AW = 7;
`ifdef DUMP_HEADER_EN
   localparam int HDR_N = 2;
`else
   localparam int HDR_N = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req0 = 1'b0;
   logic req1 = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   mem_dump_reader_if #(.ADDR_W(AW)) if0 ();
   mem_dump_reader_if #(.ADDR_W(AW)) if1 ();
   logic busy0, done0, tx0, busy1, done1, tx1;

   mem_dump_reader #(.ADDR_W(AW), .START_ADDR(0), .END_ADDR(8), .CLKS_PER_BIT(C)) dut0 (
      .CLK(clk), .RST(rst_n), .dump_req(req0), .mem(if0),
      .busy(busy0), .done(done0), .tx(tx0));
   mem_dump_reader #(.ADDR_W(AW), .START_ADDR(4), .END_ADDR(4), .CLKS_PER_BIT(C)) dut1 (
      .CLK(clk), .RST(rst_n), .dump_req(req1), .mem(if1),
      .busy(busy1), .done(done1), .tx(tx1));

   logic [31:0] ram [32];
   always @(posedge clk) begin
      if (if0.mem_rd_en) if0.mem_data <= ram[if0.mem_addr[6:2]];
      if (if1.mem_rd_en) if1.mem_data <= ram[if1.mem_addr[6:2]];
   end

   logic          tx_v [2], busy_v [2], done_v [2], rd_v [2];
   logic [AW-1:0] addr_v [2];
   assign tx_v[0] = tx0;   assign tx_v[1] = tx1;
   assign busy_v[0] = busy0; assign busy_v[1] = busy1;
   assign done_v[0] = done0; assign done_v[1] = done1;
   assign rd_v[0] = if0.mem_rd_en; assign rd_v[1] = if1.mem_rd_en;
   assign addr_v[0] = if0.mem_addr; assign addr_v[1] = if1.mem_addr;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]    exp_q  [2][$];
   logic [AW-1:0] expa_q [2][$];
   int            rd_log [2][$];
   int            done_cnt [2];
   int            done_cyc [2];
   int            rx_cnt [2];
   int            last_start [2];
   bit            rx_act [2];
   int            rx_n [2];
   logic          smp [2][10*C];
   logic          prev_rd [2];
   logic          prev_done [2];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int st_addr(input int ch);
      return (ch == 0) ? 0 : 4;
   endfunction
   function automatic int en_addr(input int ch);
      return (ch == 0) ? 8 : 4;
   endfunction

   // Monitor: read strobes, done pulses and UART frames for both channels.
   always @(negedge clk) begin
      for (int ch = 0; ch < 2; ch++) begin
         if (!rst_n) begin
            rx_act[ch]    = 1'b0;
            prev_rd[ch]   = 1'b0;
            prev_done[ch] = 1'b0;
         end else begin
            if (rd_v[ch]) begin
               chk("rd_single_cycle", prev_rd[ch], 0);
               if (expa_q[ch].size() == 0) chk("rd_unexpected", 1, 0);
               else chk("rd_addr", addr_v[ch], expa_q[ch].pop_front());
               rd_log[ch].push_back(cyc);
            end
            prev_rd[ch] = rd_v[ch];
            if (done_v[ch]) begin
               chk("done_single_cycle", prev_done[ch], 0);
               done_cnt[ch]++;
               done_cyc[ch] = cyc;
            end
            prev_done[ch] = done_v[ch];

            if (rx_act[ch]) begin
               smp[ch][rx_n[ch]] = tx_v[ch];
               rx_n[ch]++;
               if (rx_n[ch] == 10*C) begin
                  logic       ok;
                  logic [7:0] data;
                  ok = (smp[ch][0] == 1'b0) && (smp[ch][9*C] == 1'b1);
                  for (int b = 0; b < 10; b++)
                     for (int k = 0; k < C; k++)
                        if (smp[ch][b*C+k] != smp[ch][b*C]) ok = 1'b0;
                  for (int j = 0; j < 8; j++) data[j] = smp[ch][(j+1)*C];
                  chk("frame_shape", ok, 1);
                  if (exp_q[ch].size() == 0) chk("rx_unexpected", 1, 0);
                  else chk("rx_byte", data, exp_q[ch].pop_front());
                  rx_act[ch] = 1'b0;
               end
            end else if (tx_v[ch] == 1'b0) begin
               int idx;
               idx = rx_cnt[ch];
               if (idx >= HDR_N && ((idx - HDR_N) % 4) == 0) begin
                  if (rd_log[ch].size() == 0) chk("tx_without_read", 1, 0);
                  else chk("read_to_tx", cyc - rd_log[ch][$], 2);
               end else if (idx > 0) begin
                  chk("back_to_back", cyc - last_start[ch], 10*C);
               end
               last_start[ch] = cyc;
               rx_cnt[ch]++;
               rx_act[ch] = 1'b1;
               smp[ch][0] = 1'b0;
               rx_n[ch] = 1;
            end
         end
      end
   end

   // Reference model: header, then each word of the window LSB byte first.
   task automatic expect_dump(input int ch);
      logic [31:0] w;
`ifdef DUMP_HEADER_EN
      exp_q[ch].push_back(8'hA5);
      exp_q[ch].push_back(8'(st_addr(ch)));
`endif
      for (int a = st_addr(ch); a <= en_addr(ch); a += 4) begin
         w = ram[a/4];
         for (int b = 0; b < 4; b++) exp_q[ch].push_back(8'((w >> (8*b)) & 32'hFF));
         expa_q[ch].push_back(AW'(a));
      end
      rd_log[ch].delete();
      rx_cnt[ch] = 0;
   endtask

   task automatic set_req(input int ch, input logic v);
      if (ch == 0) req0 = v; else req1 = v;
   endtask

   task automatic wait_done(input int ch, input int d0);
      int i;
      i = 0;
      while (done_cnt[ch] == d0 && i < 6000) begin
         @(negedge clk); #1;
         i++;
      end
      if (done_cnt[ch] == d0) chk("done_timeout", 0, 1);
   endtask

   task automatic finish_checks(input int ch, input int d0);
      int nw;
      nw = (en_addr(ch) - st_addr(ch)) / 4 + 1;
      if (rd_log[ch].size() == 0) chk("no_reads", 0, 1);
      else chk("read_to_done_cycles", done_cyc[ch] - rd_log[ch][0], nw * (40*C + 2));
      @(negedge clk); #1;
      chk("busy_after_done", busy_v[ch], 0);
      chk("done_after_pulse", done_v[ch], 0);
      chk("addr_hold_end", addr_v[ch], en_addr(ch));
      chk("done_count", done_cnt[ch] - d0, 1);
      chk("bytes_left", exp_q[ch].size(), 0);
      chk("reads_left", expa_q[ch].size(), 0);
   endtask

   task automatic run_dump(input int ch);
      int d0;
      expect_dump(ch);
      d0 = done_cnt[ch];
      @(negedge clk);
      set_req(ch, 1'b1);
      wait_done(ch, d0);
      finish_checks(ch, d0);
      set_req(ch, 1'b0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int d0;
      int i;
      for (int k = 0; k < 32; k++) ram[k] = '0;
      ram[0] = 32'h11223344;
      ram[1] = 32'hDEADBEEF;
      ram[2] = 32'h00000080;
      for (int ch = 0; ch < 2; ch++) begin
         done_cnt[ch] = 0; done_cyc[ch] = 0; rx_cnt[ch] = 0; last_start[ch] = 0;
      end

      repeat (3) @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
         chk("rst_tx", tx_v[ch], 1);
         chk("rst_busy", busy_v[ch], 0);
         chk("rst_done", done_v[ch], 0);
         chk("rst_rd_en", rd_v[ch], 0);
         chk("rst_addr", addr_v[ch], st_addr(ch));
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic dump with the fixed pattern, then the single-word window.
      run_dump(0);
      run_dump(1);

      // Second edge during word 1 must not queue another dump.
      expect_dump(0);
      d0 = done_cnt[0];
      @(negedge clk); req0 = 1'b1;
      repeat (200) @(negedge clk);
      req0 = 1'b0;
      repeat (3) @(negedge clk);
      req0 = 1'b1;
      wait_done(0, d0);
      finish_checks(0, d0);
      repeat (600) @(negedge clk);
      chk("edge_not_queued", done_cnt[0] - d0, 1);
      req0 = 1'b0;
      repeat (2) @(negedge clk);

      // Held request gives exactly one dump.
      expect_dump(0);
      d0 = done_cnt[0];
      req0 = 1'b1;
      repeat (1000) @(negedge clk);
      chk("held_one_dump", done_cnt[0] - d0, 1);
      chk("held_bytes_left", exp_q[0].size(), 0);
      chk("held_reads_left", expa_q[0].size(), 0);
      req0 = 1'b0;
      repeat (2) @(negedge clk);

      // Asynchronous reset during the start bit of data byte 5.
      expect_dump(0);
      @(negedge clk); req0 = 1'b1;
      i = 0;
      while (rx_cnt[0] < HDR_N + 6 && i < 2000) begin
         @(negedge clk); #1;
         i++;
      end
      if (rx_cnt[0] < HDR_N + 6) chk("reset_point_timeout", 0, 1);
      chk("pre_reset_tx_low", tx0, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_tx", tx0, 1);
      chk("async_rst_busy", busy0, 0);
      chk("async_rst_rd_en", if0.mem_rd_en, 0);
      chk("async_rst_addr", if0.mem_addr, 0);
      req0 = 1'b0;
      exp_q[0].delete();
      expa_q[0].delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run_dump(0);

      // Randomized RAM contents, channel choice and idle gaps.
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 3; k++) ram[k] = $urandom;
         repeat ($urandom_range(0, 20)) @(negedge clk);
         run_dump(int'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
